mac_rx: RTL and testbench
=========================

MAC_RX -- requirements
Module: mac_rx

Interface
REQ-001 Parameter MAX_WORDS, default 511: receive buffer depth in 32-bit words; word 0 is status, words 1..MAX_WORDS-1 hold data.
REQ-002 Parameter MIN_BYTES, default 64: minimum accepted frame length in bytes, counted after the SFD and including the FCS.
REQ-003 clk_i  in  1  sole clock for the block.
REQ-004 rst_ni  in  1  reset; asynchronous, active-low.
REQ-005 rx_dv_i  in  1  carrier/data valid from the PLS decoder.
REQ-006 rx_bit_en_i  in  1  one-cycle strobe per decoded bit.
REQ-007 rxd_i  in  1  decoded bit; sampled only when rx_bit_en_i=1.
REQ-008 rx_ack_i  in  1  bus acknowledges the frame; releases the buffer.
REQ-009 buf_we_o  out  1  buffer write strobe, one-cycle pulse.
REQ-010 buf_adr_o  out  9  buffer word address.
REQ-011 buf_dat_o  out  32  buffer write data.
REQ-012 rxfull_o  out  1  level interrupt: a frame is waiting in the buffer.
REQ-013 frame_len_o  out  11  byte length of the last reported frame.
REQ-014 fcs_ok_o  out  1  FCS residue matched for the last reported frame.

Function
REQ-015 States SHALL be IDLE, HUNT, DATA, DROP, REPORT and HOLD.
- IDLE -> HUNT on rx_dv_i=1.
- HUNT: shift in bits until the last 8 received bits equal 8'b11010101 (SFD, LSB-first 0xD5), then -> DATA.
- HUNT: if rx_dv_i falls first -> IDLE, with no write.
REQ-016 DATA: bits SHALL be packed LSB-first.
- The first bit after the SFD goes to bit 0 of word 1.
- Each completed word is written on the cycle after its 32nd bit strobe, to address 1, 2, 3 ... in order.
REQ-017 In DATA, a falling rx_dv_i SHALL flush any partial word (unfilled upper bits = 0) on the next cycle, then go to REPORT.
REQ-018 A bit count that is not a multiple of 8 at end of frame SHALL force fcs_ok_o=0.
- frame_len_o = bit count / 8, truncated.
REQ-019 A frame shorter than MIN_BYTES SHALL be discarded: return to IDLE with no status write and rxfull_o unchanged.
REQ-020 When word MAX_WORDS would be exceeded, the block SHALL stop writing data and enter DROP.
- DROP waits for rx_dv_i=0, then goes to REPORT with the overflow bit set and fcs_ok=0.
REQ-021 REPORT SHALL write word 0 in one cycle, then go to HOLD.
- Word 0 format: [10:0] byte length, [16] fcs_ok, [17] overflow, all other bits 0.
- frame_len_o and fcs_ok_o update in the same cycle.
- rxfull_o = 1 from the following cycle.
REQ-022 HOLD: rx_ack_i=1 SHALL clear rxfull_o on the next cycle and go to IDLE.
- Frames arriving while in HOLD are ignored entirely.
- After the ack, reception restarts only at the next rising edge of rx_dv_i, never mid-frame.
REQ-023 The FCS SHALL be computed serially over every post-SFD bit, FCS included.
- Polynomial 0x04C11DB7, MSB-shift form, initialised to 32'hFFFFFFFF at SFD.
- fcs_ok = (final register == 32'hC704DD7B).
REQ-024 rx_bit_en_i pulses when rx_dv_i=0 SHALL be ignored.
REQ-025 An rx_dv_i fall coincident with a final bit strobe SHALL count that bit before ending the frame.

Reset
REQ-026 Assertion of rst_ni SHALL immediately force, including mid-frame:
- state = IDLE;
- buf_we_o = 0, buf_adr_o = 0, buf_dat_o = 0;
- rxfull_o = 0, frame_len_o = 0, fcs_ok_o = 0;
- bit, word and FCS registers cleared.
REQ-027 A partially received frame interrupted by reset SHALL never be reported.

Configuration
REQ-028 Macro MAC_RX_FCS_CHECK_EN SHALL control the FCS checker.
- Defined: the FCS checker is compiled in and behaves per REQ-023.
- Undefined: no CRC logic is present; fcs_ok is 1 unless REQ-018 or REQ-020 forces 0.

Structure
REQ-029 Package mac_pkg SHALL hold:
- the state enumeration typedef;
- CRC_POLY, CRC_INIT and CRC_RESIDUE constants;
- the SFD constant;
- the word-0 status bit positions, shared with the TX side.
REQ-030 The serial CRC SHALL be one sub-module, crc32_serial, with ports: clock, reset, init, enable, bit in, 32-bit value out.

Verification
REQ-031 Benches SHALL cover the following scenarios.
- 7x 0x55 + 0xD5 + 60 payload bytes + correct FCS -> words 1..16 written, word 0 = 0x0001_0040, rxfull_o=1, fcs_ok_o=1.
- Same frame with one payload bit flipped -> word 0 = 0x0000_0040, fcs_ok_o=0.
- 40-byte frame after SFD -> no word-0 write, rxfull_o stays 0.
- 2100-byte frame -> last data write at address 510, word 0 bit17=1, fcs_ok_o=0.
- rst_ni low after 100 data bits -> all outputs 0 within the same cycle; the next valid frame is received correctly.
- Second frame while rxfull_o=1 -> no buffer writes; rx_ack_i then a third frame -> third frame reported.

Source files
------------

// File: rtl/mac_pkg.sv
// mac_pkg: shared definitions for the MAC receive path (and the TX side).
//   rx_state_e      receive FSM state encoding
//   CRC_POLY/INIT/RESIDUE  serial FCS constants (MSB-shift form)
//   SFD             start-of-frame delimiter as seen LSB-first (0xD5)
//   STAT_*          bit positions inside buffer word 0 (frame status)
//   status_word()   assembles word 0 from length / fcs_ok / overflow
package mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HUNT,
        DATA,
        DROP,
        REPORT,
        HOLD
    } rx_state_e;

    localparam logic [31:0] CRC_POLY    = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hC704_DD7B;

    localparam logic [7:0]  SFD = 8'hD5;

    localparam int unsigned STAT_LEN_LSB    = 0;
    localparam int unsigned STAT_LEN_W      = 11;
    localparam int unsigned STAT_FCS_OK_BIT = 16;
    localparam int unsigned STAT_OVF_BIT    = 17;

    function automatic logic [31:0] status_word(input logic [STAT_LEN_W-1:0] len,
                                                input logic                  fcs_ok,
                                                input logic                  ovf);
        logic [31:0] w;
        w = '0;
        w[STAT_LEN_LSB +: STAT_LEN_W] = len;
        w[STAT_FCS_OK_BIT]            = fcs_ok;
        w[STAT_OVF_BIT]               = ovf;
        return w;
    endfunction

endpackage

// File: rtl/crc32_serial.sv
// crc32_serial: bit-serial CRC-32 (poly 0x04C11DB7, MSB-shift form).
// Only compiled when MAC_RX_FCS_CHECK_EN is defined.
//   clk_i   clock
//   rst_ni  asynchronous active-low reset, clears the register to 0
//   init_i  load CRC_INIT (takes priority over en_i)
//   en_i    shift one bit in
//   bit_i   serial data bit
//   crc_o   current register value
`ifdef MAC_RX_FCS_CHECK_EN
module crc32_serial
    import mac_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        init_i,
    input  logic        en_i,
    input  logic        bit_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q <= '0;
        end else if (init_i) begin
            crc_q <= CRC_INIT;
        end else if (en_i) begin
            crc_q <= {crc_q[30:0], 1'b0} ^ ((crc_q[31] ^ bit_i) ? CRC_POLY : '0);
        end
    end

    assign crc_o = crc_q;

endmodule
`endif

// File: rtl/mac_rx.sv
// mac_rx: serial Ethernet receive path into a word buffer.
// Hunts for the SFD, packs post-SFD bits LSB-first into 32-bit words
// written at addresses 1.., then writes a status word at address 0 and
// holds rxfull_o until rx_ack_i.
// Build option: MAC_RX_FCS_CHECK_EN compiles in the serial FCS checker;
// without it fcs_ok only reflects alignment and overflow.
//   clk_i        clock
//   rst_ni       asynchronous active-low reset
//   rx_dv_i      carrier / data valid
//   rx_bit_en_i  one-cycle strobe per decoded bit
//   rxd_i        decoded bit
//   rx_ack_i     bus has consumed the frame
//   buf_we_o     buffer write strobe
//   buf_adr_o    buffer word address
//   buf_dat_o    buffer write data
//   rxfull_o     a frame is waiting in the buffer
//   frame_len_o  byte length of last reported frame
//   fcs_ok_o     FCS status of last reported frame
module mac_rx
    import mac_pkg::*;
#(
    parameter int unsigned MAX_WORDS = 511,
    parameter int unsigned MIN_BYTES = 64
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_dv_i,
    input  logic        rx_bit_en_i,
    input  logic        rxd_i,
    input  logic        rx_ack_i,
    output logic        buf_we_o,
    output logic [8:0]  buf_adr_o,
    output logic [31:0] buf_dat_o,
    output logic        rxfull_o,
    output logic [10:0] frame_len_o,
    output logic        fcs_ok_o
);

    rx_state_e   state_q, state_d;
    logic        dv_q;
    logic [6:0]  hunt_sr_q;
    logic [13:0] bit_cnt_q;
    logic [9:0]  word_adr_q;
    logic [31:0] data_sr_q;
    logic        ovf_q;

    logic [7:0]  hunt_next;
    logic        sfd_hit;
    logic        room;
    logic        take;
    logic        ovf_hit;
    logic [13:0] cnt_next;
    logic [31:0] sr_next;
    logic        word_done;
    logic        flush;
    logic [10:0] len;
    logic        report_wr;
    logic        fcs_ok;
    logic        crc_ok;

`ifdef MAC_RX_FCS_CHECK_EN
    logic [31:0] crc_val;

    crc32_serial u_crc (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .init_i (sfd_hit),
        .en_i   (take),
        .bit_i  (rxd_i),
        .crc_o  (crc_val)
    );

    assign crc_ok = (crc_val == CRC_RESIDUE);
`else
    assign crc_ok = 1'b1;
`endif

    always_comb begin
        // Newest bit enters at the top, so an LSB-first SFD reads as 0xD5.
        hunt_next = {rxd_i, hunt_sr_q};
        sfd_hit   = (state_q == HUNT) && rx_dv_i && rx_bit_en_i && (hunt_next == SFD);
        room      = ({22'd0, word_adr_q} < MAX_WORDS);
        // In DATA the strobe is honoured even in the cycle rx_dv_i drops, so
        // a final bit coincident with the carrier fall is still counted.
        take      = (state_q == DATA) && rx_bit_en_i && room;
        ovf_hit   = (state_q == DATA) && rx_bit_en_i && !room;
        cnt_next  = bit_cnt_q + {13'd0, take};
        sr_next   = data_sr_q;
        if (take) begin
            sr_next[bit_cnt_q[4:0]] = rxd_i;
        end
        word_done = take && (bit_cnt_q[4:0] == 5'd31);
        flush     = (state_q == DATA) && !rx_dv_i && !ovf_hit && (cnt_next[4:0] != 5'd0);
        len       = bit_cnt_q[13:3];
        report_wr = (state_q == REPORT) && (ovf_q || ({21'd0, len} >= MIN_BYTES));
        fcs_ok    = crc_ok && (bit_cnt_q[2:0] == 3'd0) && !ovf_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rx_dv_i && !dv_q) state_d = HUNT;
            HUNT: begin
                if (!rx_dv_i)     state_d = IDLE;
                else if (sfd_hit) state_d = DATA;
            end
            DATA: begin
                if (ovf_hit)       state_d = DROP;
                else if (!rx_dv_i) state_d = REPORT;
            end
            DROP:    if (!rx_dv_i) state_d = REPORT;
            REPORT:  state_d = report_wr ? HOLD : IDLE;
            HOLD:    if (rx_ack_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            // dv_q comes out of reset high so a frame already in flight
            // cannot produce a rising edge and be picked up mid-frame.
            dv_q        <= 1'b1;
            hunt_sr_q   <= '0;
            bit_cnt_q   <= '0;
            word_adr_q  <= '0;
            data_sr_q   <= '0;
            ovf_q       <= 1'b0;
            buf_we_o    <= 1'b0;
            buf_adr_o   <= '0;
            buf_dat_o   <= '0;
            rxfull_o    <= 1'b0;
            frame_len_o <= '0;
            fcs_ok_o    <= 1'b0;
        end else begin
            dv_q     <= rx_dv_i;
            buf_we_o <= 1'b0;

            if (state_q == IDLE) begin
                hunt_sr_q <= '0;
            end
            if ((state_q == HUNT) && rx_dv_i && rx_bit_en_i) begin
                hunt_sr_q <= hunt_next[7:1];
            end

            if (sfd_hit) begin
                bit_cnt_q  <= '0;
                word_adr_q <= 10'd1;
                data_sr_q  <= '0;
                ovf_q      <= 1'b0;
            end

            if (take) begin
                bit_cnt_q <= cnt_next;
                data_sr_q <= sr_next;
            end
            if (word_done || flush) begin
                buf_we_o  <= 1'b1;
                buf_adr_o <= word_adr_q[8:0];
                buf_dat_o <= sr_next;
                data_sr_q <= '0;
            end
            if (word_done) begin
                word_adr_q <= word_adr_q + 10'd1;
            end
            if (ovf_hit) begin
                ovf_q <= 1'b1;
            end

            if (report_wr) begin
                buf_we_o    <= 1'b1;
                buf_adr_o   <= '0;
                buf_dat_o   <= status_word(len, fcs_ok, ovf_q);
                frame_len_o <= len;
                fcs_ok_o    <= fcs_ok;
            end

            if (state_q == HOLD) begin
                rxfull_o <= !rx_ack_i;
            end
        end
    end

endmodule

// File: tb/tb_mac_rx.sv
// tb_mac_rx: directed self-checking bench for mac_rx.
// Expected FCS verdicts for corrupted frames depend on MAC_RX_FCS_CHECK_EN.
module tb_mac_rx;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        rx_dv_i;
    logic        rx_bit_en_i;
    logic        rxd_i;
    logic        rx_ack_i;
    logic        buf_we_o;
    logic [8:0]  buf_adr_o;
    logic [31:0] buf_dat_o;
    logic        rxfull_o;
    logic [10:0] frame_len_o;
    logic        fcs_ok_o;

`ifdef MAC_RX_FCS_CHECK_EN
    localparam logic CRC_ON = 1'b1;
`else
    localparam logic CRC_ON = 1'b0;
`endif

    mac_rx #(.MAX_WORDS(511), .MIN_BYTES(64)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .rx_dv_i     (rx_dv_i),
        .rx_bit_en_i (rx_bit_en_i),
        .rxd_i       (rxd_i),
        .rx_ack_i    (rx_ack_i),
        .buf_we_o    (buf_we_o),
        .buf_adr_o   (buf_adr_o),
        .buf_dat_o   (buf_dat_o),
        .rxfull_o    (rxfull_o),
        .frame_len_o (frame_len_o),
        .fcs_ok_o    (fcs_ok_o)
    );

    always #5 clk_i = ~clk_i;

    // Write monitor: records buffer traffic, sampled on the falling edge.
    int unsigned data_wr_n = 0;
    int unsigned stat_wr_n = 0;
    logic [8:0]  last_data_adr = '0;
    logic [31:0] last_stat = '0;
    logic [31:0] mem [0:511];

    always @(negedge clk_i) begin
        if (buf_we_o) begin
            if (buf_adr_o == 9'd0) begin
                stat_wr_n = stat_wr_n + 1;
                last_stat = buf_dat_o;
            end else begin
                data_wr_n     = data_wr_n + 1;
                last_data_adr = buf_adr_o;
                mem[buf_adr_o] = buf_dat_o;
            end
        end
    end

    int total = 0;
    int bad   = 0;
    int unsigned d0, s0;

    logic fb [0:16999];
    int   fb_n;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic b);
        return {c[30:0], 1'b0} ^ ((c[31] ^ b) ? 32'h04C1_1DB7 : 32'h0);
    endfunction

    // Post-SFD bit stream: payload bytes LSB-first, complemented FCS MSB-first,
    // optional single-bit corruption, optional trailing 1,0,1,... bits.
    task automatic build_frame(input int npay, input int flip, input int extra);
        logic [31:0] c;
        logic [7:0]  pb;
        fb_n = 0;
        c    = 32'hFFFF_FFFF;
        for (int i = 0; i < npay; i++) begin
            pb = 8'(i * 37 + 11);
            for (int j = 0; j < 8; j++) begin
                fb[fb_n] = pb[j];
                c = crc_step(c, pb[j]);
                fb_n++;
            end
        end
        for (int j = 31; j >= 0; j--) begin
            fb[fb_n] = ~c[j];
            fb_n++;
        end
        if (flip >= 0) fb[flip] = ~fb[flip];
        for (int j = 0; j < extra; j++) begin
            fb[fb_n] = ((j % 2) == 0);
            fb_n++;
        end
    endtask

    function automatic logic [31:0] exp_word(input int k);
        logic [31:0] w;
        int idx;
        w = '0;
        for (int j = 0; j < 32; j++) begin
            idx = (k - 1) * 32 + j;
            if (idx < fb_n) w[j] = fb[idx];
        end
        return w;
    endfunction

    task automatic send_bit(input logic b);
        rxd_i       = b;
        rx_bit_en_i = 1'b1;
        tick(1);
        rx_bit_en_i = 1'b0;
        tick(1);
    endtask

    task automatic send_preamble();
        logic [7:0] pb;
        rx_dv_i = 1'b1;
        tick(2);
        for (int i = 0; i < 8; i++) begin
            pb = (i == 7) ? 8'hD5 : 8'h55;
            for (int j = 0; j < 8; j++) send_bit(pb[j]);
        end
    endtask

    task automatic send_frame(input logic fall_with_last);
        send_preamble();
        for (int i = 0; i < fb_n - 1; i++) send_bit(fb[i]);
        if (fall_with_last) begin
            rxd_i       = fb[fb_n-1];
            rx_bit_en_i = 1'b1;
            rx_dv_i     = 1'b0;
            tick(1);
            rx_bit_en_i = 1'b0;
        end else begin
            send_bit(fb[fb_n-1]);
            rx_dv_i = 1'b0;
        end
        tick(12);
    endtask

    task automatic ack();
        rx_ack_i = 1'b1;
        tick(1);
        rx_ack_i = 1'b0;
        tick(2);
    endtask

    task automatic snap();
        d0 = data_wr_n;
        s0 = stat_wr_n;
    endtask

    initial begin
        rst_ni      = 1'b0;
        rx_dv_i     = 1'b0;
        rx_bit_en_i = 1'b0;
        rxd_i       = 1'b0;
        rx_ack_i    = 1'b0;
        tick(3);
        chk("rst_we_adr", 32'({buf_we_o, buf_adr_o}), 32'd0);
        chk("rst_dat", buf_dat_o, 32'd0);
        chk("rst_flags", 32'({rxfull_o, fcs_ok_o, frame_len_o}), 32'd0);
        rst_ni = 1'b1;
        tick(2);

        // Good 64-byte frame
        build_frame(60, -1, 0);
        snap();
        send_frame(1'b0);
        chk("good_data_writes", data_wr_n - d0, 32'd16);
        chk("good_status_writes", stat_wr_n - s0, 32'd1);
        chk("good_word1", mem[1], exp_word(1));
        chk("good_word16", mem[16], exp_word(16));
        chk("good_status", last_stat, 32'h0001_0040);
        chk("good_flags", 32'({rxfull_o, fcs_ok_o, frame_len_o}), 32'({1'b1, 1'b1, 11'd64}));
        ack();
        chk("ack_clears_rxfull", 32'(rxfull_o), 32'd0);

        // Same frame, one payload bit flipped
        build_frame(60, 100, 0);
        send_frame(1'b0);
        chk("flip_status", last_stat, CRC_ON ? 32'h0000_0040 : 32'h0001_0040);
        chk("flip_fcs_ok", 32'(fcs_ok_o), CRC_ON ? 32'd0 : 32'd1);
        ack();

        // 40-byte frame is discarded
        build_frame(36, -1, 0);
        snap();
        send_frame(1'b0);
        chk("short_no_status", stat_wr_n - s0, 32'd0);
        chk("short_rxfull", 32'(rxfull_o), 32'd0);
        chk("short_data_writes", data_wr_n - d0, 32'd10);

        // 64 bytes + 3 stray bits: partial flush, misaligned -> fcs_ok 0
        build_frame(60, -1, 3);
        snap();
        send_frame(1'b0);
        chk("odd_data_writes", data_wr_n - d0, 32'd17);
        chk("odd_flush_word", mem[17], 32'h0000_0005);
        chk("odd_status", last_stat, 32'h0000_0040);
        chk("odd_fcs_ok", 32'(fcs_ok_o), 32'd0);
        ack();

        // 2100-byte frame overflows the buffer
        build_frame(2096, -1, 0);
        snap();
        send_frame(1'b0);
        chk("long_last_adr", 32'(last_data_adr), 32'd510);
        chk("long_data_writes", data_wr_n - d0, 32'd510);
        chk("long_word510", mem[510], exp_word(510));
        chk("long_ovf_bit", 32'(last_stat[17]), 32'd1);
        chk("long_fcs_bit", 32'(last_stat[16]), 32'd0);
        chk("long_flags", 32'({rxfull_o, fcs_ok_o}), 32'b10);
        ack();

        // Frame while buffer full is ignored; after ack a third frame lands
        build_frame(60, -1, 0);
        send_frame(1'b0);
        chk("holdA_rxfull", 32'(rxfull_o), 32'd1);
        snap();
        send_frame(1'b0);
        chk("holdB_no_writes", (data_wr_n - d0) + (stat_wr_n - s0), 32'd0);
        chk("holdB_rxfull", 32'(rxfull_o), 32'd1);
        ack();
        chk("holdB_ack", 32'(rxfull_o), 32'd0);
        build_frame(70, -1, 0);
        snap();
        send_frame(1'b1);
        chk("third_status", last_stat, 32'h0001_004A);
        chk("third_len", 32'(frame_len_o), 32'd74);
        chk("third_data_writes", data_wr_n - d0, 32'd19);
        chk("third_word19", mem[19], exp_word(19));
        ack();

        // Reset in the middle of a frame
        build_frame(60, -1, 0);
        send_preamble();
        for (int i = 0; i < 100; i++) send_bit(fb[i]);
        rst_ni = 1'b0;
        #1;
        chk("rstmid_we_adr", 32'({buf_we_o, buf_adr_o}), 32'd0);
        chk("rstmid_dat", buf_dat_o, 32'd0);
        chk("rstmid_flags", 32'({rxfull_o, fcs_ok_o, frame_len_o}), 32'd0);
        tick(2);
        rst_ni = 1'b1;
        snap();
        for (int i = 100; i < 160; i++) send_bit(fb[i]);
        rx_dv_i = 1'b0;
        tick(12);
        chk("rstmid_no_writes", (data_wr_n - d0) + (stat_wr_n - s0), 32'd0);
        chk("rstmid_rxfull", 32'(rxfull_o), 32'd0);
        snap();
        send_frame(1'b0);
        chk("post_rst_status", last_stat, 32'h0001_0040);
        chk("post_rst_data_writes", data_wr_n - d0, 32'd16);
        chk("post_rst_word1", mem[1], exp_word(1));
        chk("post_rst_flags", 32'({rxfull_o, fcs_ok_o, frame_len_o}), 32'({1'b1, 1'b1, 11'd64}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
